operand_stack: RTL and testbench



---
 rtl/operand_stack_if.sv | 34 +++
 rtl/operand_stack.sv | 120 ++++++++++++
 tb/tb_operand_stack.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_stack_if.sv
// Operand stack port bundle: decode-side op request plus the registered stack view.
// STACK_PEEK_EN adds the peek_sel/peek_data random-read pair.
interface operand_stack_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int DW = $clog2(DEPTH + 1);

   logic             op_valid;
   logic [2:0]       op;
   logic [WIDTH-1:0] push_data;
   logic             clear_err;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [DW-1:0]    depth;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;
`ifdef STACK_PEEK_EN
   logic [$clog2(DEPTH)-1:0] peek_sel;
   logic [WIDTH-1:0]         peek_data;

   modport master (output op_valid, op, push_data, clear_err, peek_sel,
                   input  tos, nos, depth, empty, full, overflow, underflow, peek_data);
   modport slave  (input  op_valid, op, push_data, clear_err, peek_sel,
                   output tos, nos, depth, empty, full, overflow, underflow, peek_data);
`else
   modport master (output op_valid, op, push_data, clear_err,
                   input  tos, nos, depth, empty, full, overflow, underflow);
   modport slave  (input  op_valid, op, push_data, clear_err,
                   output tos, nos, depth, empty, full, overflow, underflow);
`endif
endinterface

// File: rtl/operand_stack.sv
// Parametrised operand stack, one op per clock, TOS/NOS always readable.
// Optional STACK_PEEK_EN adds a combinational read at any offset below TOS.
module operand_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input logic              clock,
   input logic              reset,
   operand_stack_if.slave   bus
);
   localparam int PW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      OP_NOP, OP_PUSH, OP_POP, OP_DUP, OP_SWAP, OP_REPLACE, OP_OVER, OP_CLEAR
   } op_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    sp_q, sp_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             has1, has2, not_full;
   logic [AW-1:0]    wr_idx, top_idx, nos_idx;

   assign has1     = (sp_q != '0);
   assign has2     = (sp_q >= PW'(2));
   assign not_full = (sp_q != PW'(DEPTH));
   // sp_q points at the first free slot; TOS and NOS sit just below it.
   assign wr_idx   = AW'(sp_q);
   assign top_idx  = AW'(sp_q - PW'(1));
   assign nos_idx  = AW'(sp_q - PW'(2));

   always_comb begin
      mem_d       = mem_q;
      sp_d        = sp_q;
      // Clearing first lets an error raised this cycle win over clear_err.
      overflow_d  = overflow_q  & ~bus.clear_err;
      underflow_d = underflow_q & ~bus.clear_err;
      if (bus.op_valid) begin
         case (op_e'(bus.op))
            OP_PUSH: begin
               if (not_full) begin
                  mem_d[wr_idx] = bus.push_data;
                  sp_d          = sp_q + PW'(1);
               end else overflow_d = 1'b1;
            end
            OP_POP: begin
               if (has1) sp_d = sp_q - PW'(1);
               else      underflow_d = 1'b1;
            end
            OP_DUP: begin
               if (!has1)          underflow_d = 1'b1;
               else if (!not_full) overflow_d  = 1'b1;
               else begin
                  mem_d[wr_idx] = mem_q[top_idx];
                  sp_d          = sp_q + PW'(1);
               end
            end
            OP_SWAP: begin
               if (has2) begin
                  mem_d[top_idx] = mem_q[nos_idx];
                  mem_d[nos_idx] = mem_q[top_idx];
               end else underflow_d = 1'b1;
            end
            OP_REPLACE: begin
               if (has2) begin
                  mem_d[nos_idx] = bus.push_data;
                  sp_d           = sp_q - PW'(1);
               end else underflow_d = 1'b1;
            end
            OP_OVER: begin
               if (!has2)          underflow_d = 1'b1;
               else if (!not_full) overflow_d  = 1'b1;
               else begin
                  mem_d[wr_idx] = mem_q[nos_idx];
                  sp_d          = sp_q + PW'(1);
               end
            end
            OP_CLEAR: sp_d = '0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sp_q        <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is intentionally not reset; entries above sp_q are never exposed.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign bus.tos       = has1 ? mem_q[top_idx] : '0;
   assign bus.nos       = has2 ? mem_q[nos_idx] : '0;
   assign bus.depth     = sp_q;
   assign bus.empty     = !has1;
   assign bus.full      = !not_full;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

`ifdef STACK_PEEK_EN
   logic [AW-1:0] peek_idx;
   logic          peek_ok;

   assign peek_ok       = (PW'(bus.peek_sel) < sp_q);
   assign peek_idx      = AW'(sp_q - PW'(1) - PW'(bus.peek_sel));
   assign bus.peek_data = peek_ok ? mem_q[peek_idx] : '0;
`endif
endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack (WIDTH=8, DEPTH=8) against a queue model.
module tb_operand_stack;
   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                          SWAP = 3'd4, REPL = 3'd5, OVER = 3'd6, CLR = 3'd7;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;

   operand_stack_if #(.WIDTH(8), .DEPTH(8)) bus ();

   operand_stack #(.WIDTH(8), .DEPTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: queue back is TOS.
   logic [7:0] stk[$];
   bit         m_ovf, m_unf;

   task automatic model_step(input bit rst, input bit v, input bit clr,
                             input logic [2:0] o, input logic [7:0] d);
      if (rst) begin
         stk.delete();
         m_ovf = 0;
         m_unf = 0;
         return;
      end
      if (clr) begin
         m_ovf = 0;
         m_unf = 0;
      end
      if (!v) return;
      case (o)
         PUSH: if (stk.size() < 8) stk.push_back(d); else m_ovf = 1;
         POP:  if (stk.size() >= 1) void'(stk.pop_back()); else m_unf = 1;
         DUP: begin
            if (stk.size() == 0)      m_unf = 1;
            else if (stk.size() == 8) m_ovf = 1;
            else                      stk.push_back(stk[stk.size()-1]);
         end
         SWAP: begin
            if (stk.size() >= 2) begin
               logic [7:0] t;
               t = stk[stk.size()-1];
               stk[stk.size()-1] = stk[stk.size()-2];
               stk[stk.size()-2] = t;
            end else m_unf = 1;
         end
         REPL: begin
            if (stk.size() >= 2) begin
               void'(stk.pop_back());
               stk[stk.size()-1] = d;
            end else m_unf = 1;
         end
         OVER: begin
            if (stk.size() < 2)       m_unf = 1;
            else if (stk.size() == 8) m_ovf = 1;
            else                      stk.push_back(stk[stk.size()-2]);
         end
         CLR: stk.delete();
         default: ;
      endcase
   endtask

   // {tos, nos, depth, empty, full, overflow, underflow}
   function automatic logic [23:0] exp_vec();
      logic [7:0] t, n;
      t = (stk.size() > 0) ? stk[stk.size()-1] : 8'h00;
      n = (stk.size() > 1) ? stk[stk.size()-2] : 8'h00;
      return {t, n, 4'(stk.size()), stk.size() == 0, stk.size() == 8, m_ovf, m_unf};
   endfunction

   function automatic logic [23:0] act_vec();
      return {bus.tos, bus.nos, bus.depth, bus.empty, bus.full, bus.overflow, bus.underflow};
   endfunction

   // One clock: drive on negedge, sample 1ns after the rising edge.
   task automatic step(input bit rst, input bit v, input bit clr,
                       input logic [2:0] o, input logic [7:0] d);
      @(negedge clock);
      reset         = rst;
      bus.op_valid  = v;
      bus.clear_err = clr;
      bus.op        = o;
      bus.push_data = d;
      @(posedge clock);
      #1;
      model_step(rst, v, clr, o, d);
   endtask

   task automatic test_reset();
      step(1, 1, 0, PUSH, 8'h5A);
      n_checks++;
      if (act_vec() !== 24'h000008) begin
         n_fail++;
         $display("FAIL reset_state got=%h want=%h", act_vec(), 24'h000008);
      end
      n_checks++;
      if (act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_model got=%h want=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_push_basic();
      step(0, 1, 0, PUSH, 8'h11);
      step(0, 1, 0, PUSH, 8'h22);
      step(0, 1, 0, PUSH, 8'h33);
      n_checks++;
      if ({bus.tos, bus.nos, bus.depth, bus.empty, bus.overflow, bus.underflow} !== {8'h33, 8'h22, 4'd3, 3'b000}) begin
         n_fail++;
         $display("FAIL push_basic got tos=%h nos=%h depth=%0d want 33/22/3", bus.tos, bus.nos, bus.depth);
      end
   endtask

   task automatic test_overflow();
      for (int i = 4; i <= 8; i++) step(0, 1, 0, PUSH, 8'(i * 8'h11));
      step(0, 1, 0, PUSH, 8'hAA);
      n_checks++;
      if ({bus.depth, bus.full, bus.overflow, bus.tos} !== {4'd8, 1'b1, 1'b1, 8'h88}) begin
         n_fail++;
         $display("FAIL overflow got depth=%0d full=%b ovf=%b tos=%h want 8/1/1/88", bus.depth, bus.full, bus.overflow, bus.tos);
      end
      step(0, 0, 1, NOP, 8'h00);
      n_checks++;
      if (bus.overflow !== 1'b0 || act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL clear_err got=%h want=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_underflow();
      step(0, 1, 0, CLR, 8'h00);
      step(0, 1, 0, POP, 8'h00);
      step(0, 1, 0, SWAP, 8'h00);
      n_checks++;
      if ({bus.underflow, bus.overflow, bus.depth, bus.tos} !== {1'b1, 1'b0, 4'd0, 8'h00}) begin
         n_fail++;
         $display("FAIL underflow got unf=%b ovf=%b depth=%0d tos=%h want 1/0/0/00", bus.underflow, bus.overflow, bus.depth, bus.tos);
      end
      step(0, 1, 0, PUSH, 8'h05);
      step(0, 1, 0, DUP, 8'h00);
      n_checks++;
      if ({bus.tos, bus.nos, bus.depth} !== {8'h05, 8'h05, 4'd2}) begin
         n_fail++;
         $display("FAIL dup got tos=%h nos=%h depth=%0d want 05/05/2", bus.tos, bus.nos, bus.depth);
      end
      step(0, 1, 1, CLR, 8'h00);
      step(0, 1, 0, DUP, 8'h00);
      n_checks++;
      if ({bus.underflow, bus.overflow} !== 2'b10) begin
         n_fail++;
         $display("FAIL dup_empty got unf=%b ovf=%b want 1/0", bus.underflow, bus.overflow);
      end
   endtask

   task automatic test_swap_replace_over();
      step(0, 1, 1, CLR, 8'h00);
      step(0, 1, 0, PUSH, 8'h03);
      step(0, 1, 0, PUSH, 8'h04);
      step(0, 1, 0, SWAP, 8'h00);
      n_checks++;
      if ({bus.tos, bus.nos, bus.depth} !== {8'h03, 8'h04, 4'd2}) begin
         n_fail++;
         $display("FAIL swap got tos=%h nos=%h depth=%0d want 03/04/2", bus.tos, bus.nos, bus.depth);
      end
      step(0, 1, 0, REPL, 8'h07);
      n_checks++;
      if ({bus.tos, bus.nos, bus.depth} !== {8'h07, 8'h00, 4'd1}) begin
         n_fail++;
         $display("FAIL replace got tos=%h nos=%h depth=%0d want 07/00/1", bus.tos, bus.nos, bus.depth);
      end
      step(0, 1, 0, OVER, 8'h00);
      n_checks++;
      if ({bus.underflow, bus.depth, bus.tos} !== {1'b1, 4'd1, 8'h07}) begin
         n_fail++;
         $display("FAIL over_short got unf=%b depth=%0d tos=%h want 1/1/07", bus.underflow, bus.depth, bus.tos);
      end
      // Error raised in the same cycle as clear_err must stick.
      step(0, 1, 1, OVER, 8'h00);
      n_checks++;
      if (bus.underflow !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_vs_err got unf=%b want 1", bus.underflow);
      end
   endtask

   task automatic test_back_to_back();
      step(0, 1, 1, PUSH, 8'h01);
      step(0, 1, 0, PUSH, 8'h02);
      step(1, 1, 1, PUSH, 8'h03);
      n_checks++;
      if (act_vec() !== 24'h000008) begin
         n_fail++;
         $display("FAIL reset_mid got=%h want=%h", act_vec(), 24'h000008);
      end
      for (int i = 0; i < 5; i++) step(0, 1, 0, PUSH, 8'($urandom));
      step(0, 1, 0, CLR, 8'h00);
      n_checks++;
      if (act_vec() !== 24'h000008) begin
         n_fail++;
         $display("FAIL clear_op got=%h want=%h", act_vec(), 24'h000008);
      end
   endtask

   task automatic test_random();
      logic [2:0] o;
      bit         v, clr, rst;
      for (int i = 0; i < 600; i++) begin
         o   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) o = PUSH;
         if (o == CLR && $urandom_range(0, 3) != 0) o = NOP;
         v   = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 99) == 0);
         step(rst, v, clr, o, 8'($urandom));
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random[%0d] op=%0d v=%b got=%h want=%h", i, o, v, act_vec(), exp_vec());
         end
      end
   endtask

`ifdef STACK_PEEK_EN
   task automatic test_peek();
      logic [7:0] want;
      step(0, 1, 1, CLR, 8'h00);
      step(0, 1, 0, PUSH, 8'h10);
      step(0, 1, 0, PUSH, 8'h20);
      step(0, 1, 0, PUSH, 8'h30);
      step(0, 0, 0, NOP, 8'h00);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         bus.peek_sel = 3'(i);
         #1;
         want = (i < stk.size()) ? stk[stk.size()-1-i] : 8'h00;
         n_checks++;
         if (bus.peek_data !== want) begin
            n_fail++;
            $display("FAIL peek[%0d] got=%h want=%h", i, bus.peek_data, want);
         end
      end
   endtask
`endif

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      bus.op_valid  = 1'b0;
      bus.op        = NOP;
      bus.push_data = 8'h00;
      bus.clear_err = 1'b0;
`ifdef STACK_PEEK_EN
      bus.peek_sel  = '0;
`endif
      test_reset();
      test_push_basic();
      test_overflow();
      test_underflow();
      test_swap_replace_over();
      test_back_to_back();
      test_random();
`ifdef STACK_PEEK_EN
      test_peek();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
